// File: rtl/token_encoder.sv
// Word-to-token encoder: scans zero-separated bytes and looks each word
// up in a vocab table, emitting one token ID per word on a valid/ready stream.
module token_encoder #(
   parameter int DATA_WIDTH     = 8,
   parameter int IN_ADDR_WIDTH  = 8,
   parameter int VOCAB_SIZE     = 16,
   parameter int MAX_WORD_LEN   = 8,
   parameter int ID_WIDTH       = 5,
   parameter int UNK_ID         = 31,
   parameter int VOC_ADDR_WIDTH = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [IN_ADDR_WIDTH-1:0]  in_base,
   input  logic [IN_ADDR_WIDTH-1:0]  in_len,
   output logic                      busy,
   output logic                      done,
   output logic                      in_rd_en,
   output logic [IN_ADDR_WIDTH-1:0]  in_addr,
   input  logic [DATA_WIDTH-1:0]     in_rdata,
   output logic                      voc_rd_en,
   output logic [VOC_ADDR_WIDTH-1:0] voc_addr,
   input  logic [DATA_WIDTH-1:0]     voc_rdata,
   output logic                      token_valid,
   input  logic                      token_ready,
   output logic [ID_WIDTH-1:0]       token_id,
   output logic [15:0]               token_count
);

   localparam int WW = $clog2(MAX_WORD_LEN + 1);
   localparam int BW = (MAX_WORD_LEN > 1) ? $clog2(MAX_WORD_LEN) : 1;
   localparam int EW = $clog2(VOCAB_SIZE + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_IN, S_CAP_IN, S_MATCH,
      S_V_RD, S_V_CMP, S_EMIT, S_DONE
   } state_e;

   state_e                   state_q, state_d;
   logic [IN_ADDR_WIDTH-1:0] base_q, base_d;
   logic [IN_ADDR_WIDTH-1:0] len_q, len_d;
   logic [IN_ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [WW-1:0]            wlen_q, wlen_d;
   logic                     ovf_q, ovf_d;
   logic [EW-1:0]            e_q, e_d;
   logic [WW-1:0]            k_q, k_d;
   logic [ID_WIDTH-1:0]      id_q, id_d;
   logic [15:0]              cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]    wbuf_q [MAX_WORD_LEN];
   logic [DATA_WIDTH-1:0]    wbuf_d [MAX_WORD_LEN];

   logic [DATA_WIDTH-1:0]    exp_c;
   logic                     last_pos;
   logic                     has_word;
   logic [EW-1:0]            e_nxt;

   assign has_word = (wlen_q != '0) || ovf_q;
   assign e_nxt    = e_q + EW'(1);
   assign exp_c    = (k_q < wlen_q) ? wbuf_q[k_q[BW-1:0]] : '0;
   // A full-length word has no terminating 0 inside the slot
   assign last_pos = (k_q == wlen_q) ||
                     ((wlen_q == WW'(MAX_WORD_LEN)) &&
                      (k_q == WW'(MAX_WORD_LEN - 1)));

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      ptr_d   = ptr_q;
      wlen_d  = wlen_q;
      ovf_d   = ovf_q;
      e_d     = e_q;
      k_d     = k_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      wbuf_d  = wbuf_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = in_base;
               len_d   = in_len;
               ptr_d   = '0;
               wlen_d  = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_RD_IN;
            end
         end
         S_RD_IN: begin
            if (ptr_q == len_q)
               state_d = has_word ? S_MATCH : S_DONE;
            else
               state_d = S_CAP_IN;
         end
         S_CAP_IN: begin
            ptr_d = ptr_q + IN_ADDR_WIDTH'(1);
            if (in_rdata != '0) begin
               if (wlen_q < WW'(MAX_WORD_LEN)) begin
                  wbuf_d[wlen_q[BW-1:0]] = in_rdata;
                  wlen_d = wlen_q + WW'(1);
               end else begin
                  ovf_d = 1'b1;
               end
               state_d = S_RD_IN;
            end else begin
               state_d = has_word ? S_MATCH : S_RD_IN;
            end
         end
         S_MATCH: begin
            if (ovf_q) begin
               id_d    = ID_WIDTH'(UNK_ID);
               state_d = S_EMIT;
            end else begin
               e_d     = '0;
               k_d     = '0;
               state_d = S_V_RD;
            end
         end
         S_V_RD: state_d = S_V_CMP;
         S_V_CMP: begin
            if (voc_rdata != exp_c) begin
               e_d = e_nxt;
               k_d = '0;
               if (e_nxt == EW'(VOCAB_SIZE)) begin
                  id_d    = ID_WIDTH'(UNK_ID);
                  state_d = S_EMIT;
               end else begin
                  state_d = S_V_RD;
               end
            end else if (last_pos) begin
               id_d    = ID_WIDTH'(e_q);
               state_d = S_EMIT;
            end else begin
               k_d     = k_q + WW'(1);
               state_d = S_V_RD;
            end
         end
         S_EMIT: begin
            if (token_ready) begin
               cnt_d   = cnt_q + 16'd1;
               wlen_d  = '0;
               ovf_d   = 1'b0;
               state_d = S_RD_IN;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         ptr_q   <= '0;
         wlen_q  <= '0;
         ovf_q   <= 1'b0;
         e_q     <= '0;
         k_q     <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < MAX_WORD_LEN; i++)
            wbuf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         ptr_q   <= ptr_d;
         wlen_q  <= wlen_d;
         ovf_q   <= ovf_d;
         e_q     <= e_d;
         k_q     <= k_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         wbuf_q  <= wbuf_d;
      end
   end

   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done        = (state_q == S_DONE);
   assign in_rd_en    = (state_q == S_RD_IN) && (ptr_q != len_q);
   assign in_addr     = base_q + ptr_q;
   assign voc_rd_en   = (state_q == S_V_RD);
   assign voc_addr    = VOC_ADDR_WIDTH'(e_q) * VOC_ADDR_WIDTH'(MAX_WORD_LEN)
                      + VOC_ADDR_WIDTH'(k_q);
   assign token_valid = (state_q == S_EMIT);
   assign token_id    = id_q;
   assign token_count = cnt_q;

endmodule

// File: tb/tb_token_encoder.sv
// Directed bench for token_encoder with behavioural text and vocab SRAMs.
module tb_token_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  in_base;
   logic [7:0]  in_len;
   logic        busy;
   logic        done;
   logic        in_rd_en;
   logic [7:0]  in_addr;
   logic [7:0]  in_rdata;
   logic        voc_rd_en;
   logic [6:0]  voc_addr;
   logic [7:0]  voc_rdata;
   logic        token_valid;
   logic        token_ready;
   logic [4:0]  token_id;
   logic [15:0] token_count;

   logic [7:0] tmem [256];
   logic [7:0] vmem [128];

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int voc_cnt = 0;
   int tokq [$];
   int vocq [$];

   always #5 clk = ~clk;

   token_encoder dut (
      .clk(clk), .rst(rst), .start(start),
      .in_base(in_base), .in_len(in_len),
      .busy(busy), .done(done),
      .in_rd_en(in_rd_en), .in_addr(in_addr), .in_rdata(in_rdata),
      .voc_rd_en(voc_rd_en), .voc_addr(voc_addr), .voc_rdata(voc_rdata),
      .token_valid(token_valid), .token_ready(token_ready),
      .token_id(token_id), .token_count(token_count)
   );

   always @(posedge clk) begin
      if (in_rd_en) in_rdata <= tmem[in_addr];
      if (voc_rd_en) voc_rdata <= vmem[voc_addr];
      if (done) done_cnt <= done_cnt + 1;
      if (voc_rd_en) voc_cnt <= voc_cnt + 1;
      if (token_valid && token_ready) begin
         tokq.push_back(int'(token_id));
         vocq.push_back(voc_cnt);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic put_t(input int base, input string s);
      for (int i = 0; i < s.len(); i++) tmem[base+i] = s[i];
   endtask

   task automatic put_v(input int e, input string s);
      for (int i = 0; i < s.len(); i++) vmem[e*8+i] = s[i];
   endtask

   task automatic do_start(input logic [7:0] b, input logic [7:0] l);
      tokq.delete();
      vocq.delete();
      @(negedge clk);
      in_base = b;
      in_len  = l;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      @(negedge clk);
   endtask

   task automatic scan(input logic [7:0] b, input logic [7:0] l,
                       output int cyc);
      do_start(b, l);
      wait_done(cyc);
   endtask

   int cyc;
   int d0;
   int v0;
   int n;
   logic stable;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      in_base = '0;
      in_len = '0;
      token_ready = 1'b1;
      for (int i = 0; i < 256; i++) tmem[i] = 8'd0;
      for (int i = 0; i < 128; i++) vmem[i] = 8'd0;
      put_v(0, "hi");
      put_v(1, "cat");
      put_v(2, "hello");
      put_t(0, "hi");
      put_t(3, "cat");
      put_t(16, "hel");
      put_t(32, "hell");
      put_t(48, "hello");
      put_t(66, "hi");
      put_t(80, "xxxxxxxxx");
      put_t(90, "cat");
      put_t(96, "hi");

      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_in_rd", {31'd0, in_rd_en}, 0);
      chk("rst_voc_rd", {31'd0, voc_rd_en}, 0);
      chk("rst_valid", {31'd0, token_valid}, 0);
      chk("rst_id", {27'd0, token_id}, 0);
      chk("rst_count", {16'd0, token_count}, 0);
      chk("rst_in_addr", {24'd0, in_addr}, 0);
      chk("rst_voc_addr", {25'd0, voc_addr}, 0);
      rst = 1'b0;

      d0 = done_cnt;
      do_start(8'd0, 8'd6);
      chk("busy_after_start", {31'd0, busy}, 1);
      wait_done(cyc);
      chk("hicat_ntok", tokq.size(), 2);
      chk("hicat_t0", tokq.size() > 0 ? tokq[0] : -1, 0);
      chk("hicat_t1", tokq.size() > 1 ? tokq[1] : -1, 1);
      chk("hicat_done", done_cnt - d0, 1);
      chk("hicat_count", {16'd0, token_count}, 2);
      chk("hicat_busy_end", {31'd0, busy}, 0);

      scan(8'd16, 8'd3, cyc);
      chk("hel_ntok", tokq.size(), 1);
      chk("hel_id", tokq.size() > 0 ? tokq[0] : -1, 31);
      scan(8'd32, 8'd4, cyc);
      chk("hell_id", tokq.size() > 0 ? tokq[0] : -1, 31);
      scan(8'd48, 8'd5, cyc);
      chk("hello_id", tokq.size() > 0 ? tokq[0] : -1, 2);
      chk("hello_count", {16'd0, token_count}, 1);

      scan(8'd64, 8'd6, cyc);
      chk("zeros_ntok", tokq.size(), 1);
      chk("zeros_id", tokq.size() > 0 ? tokq[0] : -1, 0);

      d0 = done_cnt;
      scan(8'd200, 8'd0, cyc);
      chk("len0_cycles", cyc, 2);
      chk("len0_ntok", tokq.size(), 0);
      chk("len0_count", {16'd0, token_count}, 0);
      chk("len0_done", done_cnt - d0, 1);

      v0 = voc_cnt;
      scan(8'd80, 8'd13, cyc);
      chk("ovf_ntok", tokq.size(), 2);
      chk("ovf_t0", tokq.size() > 0 ? tokq[0] : -1, 31);
      chk("ovf_t1", tokq.size() > 1 ? tokq[1] : -1, 1);
      chk("ovf_no_voc", vocq.size() > 0 ? vocq[0] - v0 : -1, 0);

      token_ready = 1'b0;
      do_start(8'd0, 8'd6);
      n = 0;
      while (!token_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid_seen", {31'd0, token_valid}, 1);
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!(token_valid && token_id == 5'd0 && !in_rd_en))
            stable = 1'b0;
      end
      chk("bp_stable", {31'd0, stable}, 1);
      chk("bp_no_accept", tokq.size(), 0);
      token_ready = 1'b1;
      wait_done(cyc);
      chk("bp_ntok", tokq.size(), 2);
      chk("bp_t1", tokq.size() > 1 ? tokq[1] : -1, 1);
      chk("bp_count", {16'd0, token_count}, 2);

      d0 = done_cnt;
      do_start(8'd0, 8'd6);
      n = 0;
      while (!voc_rd_en && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("mid_vrd_seen", {31'd0, voc_rd_en}, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_busy", {31'd0, busy}, 0);
      chk("mid_voc_rd", {31'd0, voc_rd_en}, 0);
      chk("mid_voc_addr", {25'd0, voc_addr}, 0);
      chk("mid_in_addr", {24'd0, in_addr}, 0);
      chk("mid_valid", {31'd0, token_valid}, 0);
      chk("mid_count", {16'd0, token_count}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_no_done", done_cnt - d0, 0);
      chk("mid_no_tok", tokq.size(), 0);
      scan(8'd96, 8'd2, cyc);
      chk("post_ntok", tokq.size(), 1);
      chk("post_id", tokq.size() > 0 ? tokq[0] : -1, 0);
      chk("post_count", {16'd0, token_count}, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
